// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared encodings, key codes and winning-line table for the tic-tac-toe sequencer
// Contents: phase_t (MAIN/PLAY/WIN/DRAW), mark codes, key codes, LINE_CELLS table,
// and board helpers cell_of / set_cell / is_cell_key.
package ttt_pkg;

  typedef enum logic [1:0] {
    PH_MAIN = 2'b00,
    PH_PLAY = 2'b01,
    PH_WIN  = 2'b10,
    PH_DRAW = 2'b11
  } phase_t;

  localparam logic [1:0] MARK_EMPTY = 2'b00;
  localparam logic [1:0] MARK_X     = 2'b01;
  localparam logic [1:0] MARK_O     = 2'b10;

  localparam logic [3:0] KEY_START = 4'd1;
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;

  // Three cell numbers (1..9) per winning line, scanned in index order.
  localparam logic [0:7][0:2][3:0] LINE_CELLS = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  function automatic logic is_cell_key(input logic [3:0] k);
    return (k >= 4'd1) && (k <= 4'd9);
  endfunction

  // Cell k occupies board bits [2k-1:2k-2].
  function automatic logic [1:0] cell_of(input logic [17:0] board, input logic [3:0] k);
    logic [4:0] base;
    base = {k, 1'b0} - 5'd2;
    return board[base +: 2];
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] board, input logic [3:0] k,
                                           input logic [1:0] mark);
    logic [17:0] b;
    logic [4:0]  base;
    b    = board;
    base = {k, 1'b0} - 5'd2;
    b[base +: 2] = mark;
    return b;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational test of one winning line against a mark
// Ports: board (18b, 2 bits per cell), line_idx (3b, 0..7), mark (2b) -> hit (all three cells equal mark).
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [2:0]  line_idx,
  input  logic [1:0]  mark,
  output logic        hit
);

  always_comb begin
    hit = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (cell_of(board, LINE_CELLS[line_idx][p]) != mark) begin
        hit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game sequencer: board, turn order, phase, win/draw scan
// Ports: clk, rst (sync active-low); key_valid/key_code (decoded keypad events);
// board, phase, turn_o, winner, win_line, move_count, busy, illegal (all registered state).
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int N_LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic [1:0]  phase,
  output logic        turn_o,
  output logic [1:0]  winner,
  output logic [2:0]  win_line,
  output logic [3:0]  move_count,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [2:0] {
    ST_MAIN,
    ST_PLAY,
    ST_CHECK,
    ST_WIN,
    ST_DRAW
  } state_t;

  localparam logic [2:0] LAST_LINE = 3'(N_LINES - 1);

  state_t      state, state_n;
  logic [17:0] board_n;
  logic        turn_n;
  logic [1:0]  winner_n;
  logic [2:0]  win_line_n;
  logic [3:0]  move_count_n;
  logic        illegal_n;
  logic [2:0]  scan_idx, scan_idx_n;
  logic [1:0]  cur_mark;
  logic        line_hit;

  // The turn only flips after a full no-win scan, so during CHECK it still
  // names the player whose mark was just placed.
  assign cur_mark = turn_o ? MARK_O : MARK_X;

  ttt_line_check u_line_check (
    .board    (board),
    .line_idx (scan_idx),
    .mark     (cur_mark),
    .hit      (line_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_MAIN;
      board      <= '0;
      turn_o     <= 1'b0;
      winner     <= MARK_EMPTY;
      win_line   <= '0;
      move_count <= '0;
      illegal    <= 1'b0;
      scan_idx   <= '0;
    end else begin
      state      <= state_n;
      board      <= board_n;
      turn_o     <= turn_n;
      winner     <= winner_n;
      win_line   <= win_line_n;
      move_count <= move_count_n;
      illegal    <= illegal_n;
      scan_idx   <= scan_idx_n;
    end
  end

  always_comb begin
    state_n      = state;
    board_n      = board;
    turn_n       = turn_o;
    winner_n     = winner;
    win_line_n   = win_line;
    move_count_n = move_count;
    illegal_n    = 1'b0;
    scan_idx_n   = scan_idx;

    case (state)
      ST_MAIN: begin
        if (key_valid && key_code == KEY_START) begin
          board_n      = '0;
          move_count_n = '0;
          winner_n     = MARK_EMPTY;
          win_line_n   = '0;
          turn_n       = 1'b0;
          state_n      = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (key_valid) begin
          if (is_cell_key(key_code)) begin
            if (cell_of(board, key_code) == MARK_EMPTY) begin
              board_n      = set_cell(board, key_code, cur_mark);
              move_count_n = move_count + 4'd1;
              scan_idx_n   = '0;
              state_n      = ST_CHECK;
            end else begin
              illegal_n = 1'b1;
            end
          end else if (key_code == KEY_STAR) begin
            state_n = ST_MAIN;
          end
        end
      end

      // Keys are not looked at here, which is what drops them while busy.
      ST_CHECK: begin
        if (line_hit) begin
          winner_n   = cur_mark;
          win_line_n = scan_idx;
          state_n    = ST_WIN;
        end else if (scan_idx == LAST_LINE) begin
          if (move_count == 4'd9) begin
            state_n = ST_DRAW;
          end else begin
            turn_n  = ~turn_o;
            state_n = ST_PLAY;
          end
        end else begin
          scan_idx_n = scan_idx + 3'd1;
        end
      end

      ST_WIN, ST_DRAW: begin
        if (key_valid && key_code == KEY_HASH) begin
          board_n      = '0;
          move_count_n = '0;
          winner_n     = MARK_EMPTY;
          win_line_n   = '0;
          turn_n       = 1'b0;
          state_n      = ST_PLAY;
        end else if (key_valid && key_code == KEY_STAR) begin
          state_n = ST_MAIN;
        end
      end

      default: state_n = ST_MAIN;
    endcase
  end

  // Decoded straight from the state flops; CHECK is presented as PLAY + busy.
  always_comb begin
    phase = PH_MAIN;
    busy  = 1'b0;
    case (state)
      ST_MAIN:  phase = PH_MAIN;
      ST_PLAY:  phase = PH_PLAY;
      ST_CHECK: begin
        phase = PH_PLAY;
        busy  = 1'b1;
      end
      ST_WIN:   phase = PH_WIN;
      ST_DRAW:  phase = PH_DRAW;
      default:  phase = PH_MAIN;
    endcase
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - directed plus randomized bench for ttt_game_ctrl against a game-rules model
module tb_ttt_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [17:0] board;
  logic [1:0]  phase;
  logic        turn_o;
  logic [1:0]  winner;
  logic [2:0]  win_line;
  logic [3:0]  move_count;
  logic        busy;
  logic        illegal;

  ttt_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .board      (board),
    .phase      (phase),
    .turn_o     (turn_o),
    .winner     (winner),
    .win_line   (win_line),
    .move_count (move_count),
    .busy       (busy),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Game-rules model: cells hold 0 empty, 1 X, 2 O; phase 0 MAIN 1 PLAY 2 WIN 3 DRAW.
  int m_cell [1:9];
  int m_phase, m_turn, m_winner, m_wl, m_mc;
  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int k = 1; k <= 9; k++) b[2*k-2 +: 2] = 2'(m_cell[k]);
    return b;
  endfunction

  task automatic model_clear_game();
    for (int k = 1; k <= 9; k++) m_cell[k] = 0;
    m_turn = 0; m_winner = 0; m_wl = 0; m_mc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    key_valid = 1'b0;
    tick();
    model_clear_game();
    m_phase = 0;
    check("rst_board", board, 0);
    check("rst_phase", phase, 0);
    check("rst_turn", turn_o, 0);
    check("rst_winner", winner, 0);
    check("rst_win_line", win_line, 0);
    check("rst_move_count", move_count, 0);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b1;
  endtask

  // Presents one key, then follows any scan to its end, checking exact timing.
  task automatic press(input logic [3:0] code, input bit inject);
    int kind;   // 0 no move, 1 illegal, 2 accepted move
    int hitl;
    int mark;
    int len;
    int inj;
    kind = 0;
    hitl = -1;
    case (m_phase)
      0: if (code == 1) begin model_clear_game(); m_phase = 1; end
      1: begin
        if (code >= 1 && code <= 9) begin
          if (m_cell[code] != 0) kind = 1;
          else begin
            kind = 2;
            mark = (m_turn == 1) ? 2 : 1;
            m_cell[code] = mark;
            m_mc++;
            for (int l = 0; l < 8; l++)
              if (hitl < 0 && m_cell[lines[l][0]] == mark && m_cell[lines[l][1]] == mark
                  && m_cell[lines[l][2]] == mark) hitl = l;
          end
        end else if (code == 10) m_phase = 0;
      end
      default: begin
        if (code == 11) begin model_clear_game(); m_phase = 1; end
        else if (code == 10) m_phase = 0;
      end
    endcase

    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;

    check("t1_board", board, model_board());
    check("t1_move_count", move_count, m_mc);
    check("t1_illegal", illegal, (kind == 1) ? 1 : 0);
    check("t1_busy", busy, (kind == 2) ? 1 : 0);
    check("t1_phase", phase, m_phase);
    check("t1_turn", turn_o, m_turn);

    if (kind == 1) begin
      tick();
      check("illegal_one_cycle", illegal, 0);
      check("illegal_phase", phase, 1);
    end

    if (kind == 2) begin
      len = (hitl >= 0) ? hitl + 1 : 8;
      inj = inject ? int'($urandom_range(0, len - 1)) : -1;
      for (int j = 0; j < len; j++) begin
        if (j == len - 1) begin
          check("scan_busy_last", busy, 1);
          check("scan_phase_last", phase, 1);
        end
        if (j == inj) begin
          key_valid = 1'b1;
          key_code  = 4'($urandom_range(1, 9));
        end
        tick();
        key_valid = 1'b0;
        check("scan_no_illegal", illegal, 0);
      end
      if (hitl >= 0) begin
        m_phase  = 2;
        m_winner = mark;
        m_wl     = hitl;
      end else if (m_mc == 9) m_phase = 3;
      else m_turn = 1 - m_turn;
      check("end_phase", phase, m_phase);
      check("end_busy", busy, 0);
      check("end_turn", turn_o, m_turn);
      check("end_board", board, model_board());
      if (m_phase == 2) check("end_win_line", win_line, m_wl);
    end

    if (m_phase != 0) check("winner", winner, m_winner);
  endtask

  initial begin
    int r;
    logic [3:0] c;

    do_reset();

    // Start
    press(4'd1, 0);
    check("start_phase", phase, 1);
    check("start_board", board, 0);
    check("start_turn", turn_o, 0);

    // Row win on line 1 (timing is checked inside press)
    press(4'd5, 0); press(4'd1, 0); press(4'd4, 0); press(4'd2, 0); press(4'd6, 0);
    check("row_phase", phase, 2);
    check("row_winner", winner, 1);
    check("row_win_line", win_line, 1);

    // Restart with #
    press(4'd11, 0);
    check("hash_phase", phase, 1);
    check("hash_board", board, 0);

    // Illegal move
    press(4'd5, 1);
    press(4'd5, 0);
    check("illegal_cell5", board[9:8], 1);
    check("illegal_turn", turn_o, 1);

    // Abort keeps board
    press(4'd10, 0);
    check("abort_phase", phase, 0);
    check("abort_board_cell5", board[9:8], 1);

    // Draw
    press(4'd1, 0);
    foreach (lines[i]) ;
    press(4'd1, 0); press(4'd2, 1); press(4'd3, 0); press(4'd5, 1); press(4'd4, 0);
    press(4'd7, 0); press(4'd8, 1); press(4'd6, 0); press(4'd9, 0);
    check("draw_phase", phase, 3);
    check("draw_move_count", move_count, 9);

    // Busy drop then reset mid-scan
    press(4'd11, 0);
    key_valid = 1'b1; key_code = 4'd5;
    tick();
    key_valid = 1'b0;
    check("mid_busy", busy, 1);
    key_valid = 1'b1; key_code = 4'd3;
    tick();
    key_valid = 1'b0;
    check("drop_cell3", board[5:4], 0);
    check("drop_no_illegal", illegal, 0);
    do_reset();

    // Randomized games
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (m_phase == 0 && ($urandom_range(0, 2) == 0)) c = 4'd1;
      else if (r < 80) c = 4'($urandom_range(1, 9));
      else if (r < 86) c = 4'd10;
      else if (r < 94) c = 4'd11;
      else begin
        c = 4'($urandom_range(11, 15));
        if (c == 4'd11) c = 4'd0;
      end
      press(c, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
